// File: rtl/ercy_pkg.sv
// Shared types and constants for the ERCY sector scheduler.
package ercy_pkg;

  localparam int unsigned SEC_BYTES = 512;
  localparam int unsigned PTR_W     = 10;
  localparam int unsigned LVL_W     = 11;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned CLST_W    = 16;
  localparam int unsigned SPC_W     = 8;

  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_XFER,
    ST_SDONE,
    ST_FIN
  } state_e;

  // Saturating increment for the cluster counter.
  function automatic logic [CLST_W-1:0] sat_inc_clst(input logic [CLST_W-1:0] v);
    return (v == {CLST_W{1'b1}}) ? v : v + CLST_W'(1);
  endfunction

endpackage

// File: rtl/ercy_clst_cntr.sv
// Sector/cluster bookkeeping: sector address, sector count, cluster count.
module ercy_clst_cntr
  import ercy_pkg::*;
#(
  parameter logic [CNT_W-1:0] MAX_SECS = 32'h0000_FFFF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              open_i,
  input  logic              adv_i,
  input  logic [CNT_W-1:0]  strt_sec_i,
  input  logic [SPC_W-1:0]  spclust_i,
  output logic [CNT_W-1:0]  wr_sec_o,
  output logic [CNT_W-1:0]  sec_cnt_o,
  output logic [CLST_W-1:0] clst_cnt_o,
  output logic              last_o
);

  logic [SPC_W-1:0]  spc_q;
  logic [SPC_W-1:0]  pos_q;
  logic [CNT_W-1:0]  wr_sec_q;
  logic [CNT_W-1:0]  sec_cnt_q;
  logic [CLST_W-1:0] clst_q;

  // Latch file geometry on open; advance sector address and cluster position per written sector.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      spc_q     <= '0;
      pos_q     <= '0;
      wr_sec_q  <= '0;
      sec_cnt_q <= '0;
      clst_q    <= '0;
    end else if (open_i) begin
      // A zero cluster size would never wrap; treat it as one sector per cluster.
      spc_q     <= (spclust_i == '0) ? SPC_W'(1) : spclust_i;
      pos_q     <= '0;
      wr_sec_q  <= strt_sec_i;
      sec_cnt_q <= '0;
      clst_q    <= '0;
    end else if (adv_i) begin
      sec_cnt_q <= sec_cnt_q + CNT_W'(1);
      wr_sec_q  <= wr_sec_q + CNT_W'(1);
      // First sector of a cluster claims a new cluster.
      if (pos_q == '0) begin
        clst_q <= sat_inc_clst(clst_q);
      end
      pos_q <= (pos_q == spc_q - SPC_W'(1)) ? '0 : pos_q + SPC_W'(1);
    end
  end

  // True when the sector being completed is the last one the file may hold.
  assign last_o = ((sec_cnt_q + CNT_W'(1)) == MAX_SECS);

  assign wr_sec_o   = wr_sec_q;
  assign sec_cnt_o  = sec_cnt_q;
  assign clst_cnt_o = clst_q;

endmodule

// File: rtl/ercy_sector_sched.sv
// ERCY file writer: packs FIFO bytes into 512-byte SD sector writes, pads on flush, reports totals.
module ercy_sector_sched
  import ercy_pkg::*;
#(
  parameter logic [CNT_W-1:0] MAX_SECS = 32'h0000_FFFF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic              flush,
  input  logic [CNT_W-1:0]  strt_sec,
  input  logic [SPC_W-1:0]  spclust,
  input  logic [LVL_W-1:0]  fifo_lvl,
  input  logic [7:0]        fifo_q,
  output logic              fifo_rd,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [CNT_W-1:0]  wr_sec,
  input  logic              dat_ld,
  output logic [7:0]        dat_out,
  input  logic              pkt_done,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CLST_W-1:0] clst_cnt,
  output logic              err_urun,
  output logic              err_full
);

  state_e           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic             flush_pend_q;
  logic             err_urun_q;
  logic             err_full_q;
  logic             busy_q;
  logic             done_q;
  logic             wr_req_q;
  logic [7:0]       dat_out_q;

  logic open_c;
  logic adv_c;
  logic last_c;
  logic fifo_nz_c;
  logic sec_avail_c;

  assign fifo_nz_c   = (fifo_lvl != '0);
  assign sec_avail_c = (fifo_lvl >= LVL_W'(SEC_BYTES));
  assign open_c      = (state_q == ST_IDLE) && start;
  assign adv_c       = (state_q == ST_SDONE) && pkt_done;

  // Pop is combinational with the transceiver's byte load so the FIFO advances in the same cycle.
  assign fifo_rd = (state_q == ST_XFER) && dat_ld && fifo_nz_c;

  ercy_clst_cntr #(
    .MAX_SECS (MAX_SECS)
  ) u_clst (
    .clk        (clk),
    .nreset     (nreset),
    .open_i     (open_c),
    .adv_i      (adv_c),
    .strt_sec_i (strt_sec),
    .spclust_i  (spclust),
    .wr_sec_o   (wr_sec),
    .sec_cnt_o  (sec_cnt),
    .clst_cnt_o (clst_cnt),
    .last_o     (last_c)
  );

  // File sequencer: sector request, byte streaming with padding, completion and error tracking.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      byte_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      err_urun_q   <= 1'b0;
      err_full_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_req_q     <= 1'b0;
      dat_out_q    <= PAD_BYTE;
    end else begin
      done_q <= 1'b0;

      // A flush may arrive at any point while the file is open.
      if ((state_q != ST_IDLE) && flush) begin
        flush_pend_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_WAIT;
            busy_q       <= 1'b1;
            byte_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            err_urun_q   <= 1'b0;
            err_full_q   <= 1'b0;
          end
        end

        ST_WAIT: begin
          // Full sector buffered, or a partial tail once the producer has flushed.
          if (sec_avail_c || (flush_pend_q && fifo_nz_c)) begin
            state_q  <= ST_REQ;
            wr_req_q <= 1'b1;
          end else if (flush_pend_q) begin
            state_q <= ST_FIN;
          end
        end

        ST_REQ: begin
          if (wr_ack) begin
            state_q  <= ST_XFER;
            wr_req_q <= 1'b0;
            ptr_q    <= '0;
          end
        end

        ST_XFER: begin
          if (dat_ld) begin
            if (fifo_nz_c) begin
              dat_out_q  <= fifo_q;
              byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end else begin
              dat_out_q <= PAD_BYTE;
              // Running dry is only legal once the producer has declared the end.
              if (!flush_pend_q) begin
                err_urun_q <= 1'b1;
              end
            end
            if (ptr_q == PTR_W'(SEC_BYTES - 1)) begin
              state_q <= ST_SDONE;
            end else begin
              ptr_q <= ptr_q + PTR_W'(1);
            end
          end
        end

        ST_SDONE: begin
          if (pkt_done) begin
            if (last_c) begin
              err_full_q <= 1'b1;
              state_q    <= ST_FIN;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end

        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_req   = wr_req_q;
  assign dat_out  = dat_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign byte_cnt = byte_cnt_q;
  assign err_urun = err_urun_q;
  assign err_full = err_full_q;

endmodule

// File: tb/tb_ercy_sector_sched.sv
// Scoreboard bench for ercy_sector_sched: FIFO model, transceiver model, done monitor.
module tb_ercy_sector_sched;

  typedef struct packed {
    logic [31:0] bytes;
    logic [31:0] secs;
    logic [15:0] clst;
    logic        urun;
    logic        full;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset   = 1'b0;
  logic        start    = 1'b0;
  logic        start_f  = 1'b0;
  logic        flush    = 1'b0;
  logic        wr_ack   = 1'b0;
  logic        dat_ld   = 1'b0;
  logic        pkt_done = 1'b0;
  logic [31:0] strt_sec = 32'h0;
  logic [7:0]  spclust  = 8'h0;
  logic [10:0] fifo_lvl;
  logic [7:0]  fifo_q;

  logic        m_fifo_rd, m_wr_req, m_busy, m_done, m_err_urun, m_err_full;
  logic [31:0] m_wr_sec, m_byte_cnt, m_sec_cnt;
  logic [7:0]  m_dat_out;
  logic [15:0] m_clst_cnt;
  logic        f_fifo_rd, f_wr_req, f_busy, f_done, f_err_urun, f_err_full;
  logic [31:0] f_wr_sec, f_byte_cnt, f_sec_cnt;
  logic [7:0]  f_dat_out;
  logic [15:0] f_clst_cnt;

  ercy_sector_sched dut (
    .clk(clk), .nreset(nreset), .start(start), .flush(flush),
    .strt_sec(strt_sec), .spclust(spclust), .fifo_lvl(fifo_lvl), .fifo_q(fifo_q),
    .fifo_rd(m_fifo_rd), .wr_req(m_wr_req), .wr_ack(wr_ack), .wr_sec(m_wr_sec),
    .dat_ld(dat_ld), .dat_out(m_dat_out), .pkt_done(pkt_done), .busy(m_busy),
    .done(m_done), .byte_cnt(m_byte_cnt), .sec_cnt(m_sec_cnt), .clst_cnt(m_clst_cnt),
    .err_urun(m_err_urun), .err_full(m_err_full)
  );

  ercy_sector_sched #(.MAX_SECS(32'd2)) dut_f (
    .clk(clk), .nreset(nreset), .start(start_f), .flush(flush),
    .strt_sec(strt_sec), .spclust(spclust), .fifo_lvl(fifo_lvl), .fifo_q(fifo_q),
    .fifo_rd(f_fifo_rd), .wr_req(f_wr_req), .wr_ack(wr_ack), .wr_sec(f_wr_sec),
    .dat_ld(dat_ld), .dat_out(f_dat_out), .pkt_done(pkt_done), .busy(f_busy),
    .done(f_done), .byte_cnt(f_byte_cnt), .sec_cnt(f_sec_cnt), .clst_cnt(f_clst_cnt),
    .err_urun(f_err_urun), .err_full(f_err_full)
  );

  // Selected DUT seen by the transceiver and done monitor.
  logic        sel_f = 1'b0;
  logic        wr_req_s, rd_s, done_s, busy_s, urun_s, full_s;
  logic [31:0] wr_sec_s, byte_cnt_s, sec_cnt_s;
  logic [7:0]  dat_out_s;
  logic [15:0] clst_s;
  assign wr_req_s   = sel_f ? f_wr_req   : m_wr_req;
  assign rd_s       = sel_f ? f_fifo_rd  : m_fifo_rd;
  assign done_s     = sel_f ? f_done     : m_done;
  assign busy_s     = sel_f ? f_busy     : m_busy;
  assign urun_s     = sel_f ? f_err_urun : m_err_urun;
  assign full_s     = sel_f ? f_err_full : m_err_full;
  assign wr_sec_s   = sel_f ? f_wr_sec   : m_wr_sec;
  assign byte_cnt_s = sel_f ? f_byte_cnt : m_byte_cnt;
  assign sec_cnt_s  = sel_f ? f_sec_cnt  : m_sec_cnt;
  assign dat_out_s  = sel_f ? f_dat_out  : m_dat_out;
  assign clst_s     = sel_f ? f_clst_cnt : m_clst_cnt;

  // Show-ahead FIFO model; drain_mode forces an empty level from byte 300 of a sector.
  logic [7:0] fq[$];
  int         fifo_cnt   = 0;
  logic [7:0] fifo_head  = 8'h00;
  logic       drain_mode = 1'b0;
  int         xidx       = 0;
  assign fifo_lvl = (drain_mode && xidx >= 300) ? 11'd0 : 11'(fifo_cnt);
  assign fifo_q   = fifo_head;

  function void fifo_sync();
    fifo_cnt  = fq.size();
    fifo_head = (fq.size() != 0) ? fq[0] : 8'h00;
  endfunction

  logic [31:0] exp_sec[$];
  logic [7:0]  exp_byte[$];
  done_t       exp_done[$];

  int n_run     = 0;
  int n_fail    = 0;
  int done_seen = 0;
  int secs_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int k, input int seed);
    return 8'(k * 7 + seed);
  endfunction

  task automatic push_data(input int n, input int seed);
    for (int i = 0; i < n; i++) fq.push_back(pat(i, seed));
    fifo_sync();
  endtask

  task automatic expect_sector(input logic [31:0] sec, input int first, input int ndata, input int seed);
    exp_sec.push_back(sec);
    for (int i = 0; i < 512; i++) exp_byte.push_back((i < ndata) ? pat(first + i, seed) : 8'h00);
  endtask

  task automatic expect_done(input int b, input int s, input int c, input logic u, input logic f);
    done_t d;
    d.bytes = 32'(b); d.secs = 32'(s); d.clst = 16'(c); d.urun = u; d.full = f;
    exp_done.push_back(d);
  endtask

  task automatic open_file(input logic [31:0] s, input logic [7:0] c, input logic on_f);
    strt_sec = s; spclust = c;
    if (on_f) start_f = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_f = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = done_seen;
    k  = 0;
    while (done_seen == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_run++;
    if (done_seen == d0) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); nreset = 1'b0;
    @(negedge clk);
    @(negedge clk); nreset = 1'b1;
  endtask

  // Transceiver model: acknowledges requests, loads 512 bytes, then reports packet done.
  initial begin : xcvr
    logic        popped;
    logic        aborted;
    logic [31:0] es;
    logic [7:0]  eb;
    forever begin
      @(negedge clk);
      if (nreset && wr_req_s) begin
        if (exp_sec.size() == 0) begin
          n_run++; n_fail++;
          $display("FAIL wr_req: unexpected request, wr_sec=0x%0h expected none", wr_sec_s);
        end else begin
          es = exp_sec.pop_front();
          check("wr_sec", wr_sec_s, es);
        end
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack  = 1'b0;
        dat_ld  = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < 512; i++) begin
          xidx = i;
          #1 popped = rd_s;
          @(negedge clk);
          if (!nreset) begin
            aborted = 1'b1;
            break;
          end
          if (popped) begin
            void'(fq.pop_front());
            fifo_sync();
          end
          if (exp_byte.size() == 0) begin
            n_run++; n_fail++;
            $display("FAIL dat_out: unexpected byte 0x%0h at %0d", dat_out_s, i);
          end else begin
            eb = exp_byte.pop_front();
            check($sformatf("dat_out[%0d]", i), 32'(dat_out_s), 32'(eb));
          end
        end
        dat_ld     = 1'b0;
        drain_mode = 1'b0;
        if (!aborted) begin
          repeat (3) @(negedge clk);
          pkt_done = 1'b1;
          @(negedge clk);
          pkt_done = 1'b0;
          secs_done++;
        end
      end
    end
  end

  // Done monitor: compares file totals whenever the selected DUT closes a file.
  always @(negedge clk) begin
    done_t d;
    if (nreset && done_s) begin
      done_seen++;
      if (exp_done.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL done: unexpected done pulse, byte_cnt=%0d", byte_cnt_s);
      end else begin
        d = exp_done.pop_front();
        check("done.byte_cnt", byte_cnt_s, d.bytes);
        check("done.sec_cnt", sec_cnt_s, d.secs);
        check("done.clst_cnt", 32'(clst_s), 32'(d.clst));
        check("done.err_urun", 32'(urun_s), 32'(d.urun));
        check("done.err_full", 32'(full_s), 32'(d.full));
        check("done.busy", 32'(busy_s), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    int d0;
    repeat (3) @(negedge clk);
    // Reset state
    check("rst.busy", 32'(m_busy), 32'd0);
    check("rst.done", 32'(m_done), 32'd0);
    check("rst.wr_req", 32'(m_wr_req), 32'd0);
    check("rst.wr_sec", m_wr_sec, 32'd0);
    check("rst.dat_out", 32'(m_dat_out), 32'd0);
    check("rst.byte_cnt", m_byte_cnt, 32'd0);
    check("rst.sec_cnt", m_sec_cnt, 32'd0);
    check("rst.clst_cnt", 32'(m_clst_cnt), 32'd0);
    check("rst.err_urun", 32'(m_err_urun), 32'd0);
    check("rst.err_full", 32'(m_err_full), 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // Two full sectors, spclust 8
    push_data(1024, 1);
    expect_sector(32'h2000, 0, 512, 1);
    expect_sector(32'h2001, 512, 512, 1);
    expect_done(1024, 2, 1, 1'b0, 1'b0);
    open_file(32'h2000, 8'd8, 1'b0);
    check("t1.busy", 32'(m_busy), 32'd1);
    pulse_flush();
    wait_done(3000);

    // Partial tail padded with zeros
    push_data(100, 3);
    expect_sector(32'h4000, 0, 100, 3);
    expect_done(100, 1, 1, 1'b0, 1'b0);
    open_file(32'h4000, 8'd8, 1'b0);
    pulse_flush();
    wait_done(2000);

    // One sector per cluster
    push_data(1536, 5);
    expect_sector(32'h2000, 0, 512, 5);
    expect_sector(32'h2001, 512, 512, 5);
    expect_sector(32'h2002, 1024, 512, 5);
    expect_done(1536, 3, 3, 1'b0, 1'b0);
    open_file(32'h2000, 8'd1, 1'b0);
    pulse_flush();
    wait_done(4000);

    // Underrun at byte 300 without flush, then flush the remainder
    xidx = 0;
    drain_mode = 1'b1;
    push_data(512, 9);
    expect_sector(32'h3000, 0, 300, 9);
    open_file(32'h3000, 8'd4, 1'b0);
    d0 = secs_done;
    k  = 0;
    while (secs_done == d0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("t4.sector_finished", 32'(secs_done - d0), 32'd1);
    repeat (2) @(negedge clk);
    check("t4.err_urun", 32'(m_err_urun), 32'd1);
    check("t4.busy", 32'(m_busy), 32'd1);
    check("t4.byte_cnt", m_byte_cnt, 32'd300);
    expect_sector(32'h3001, 300, 212, 9);
    expect_done(512, 2, 1, 1'b1, 1'b0);
    pulse_flush();
    wait_done(2000);

    // Sector limit of 2 on the second instance
    sel_f = 1'b1;
    push_data(1536, 11);
    expect_sector(32'h0100, 0, 512, 11);
    expect_sector(32'h0101, 512, 512, 11);
    expect_done(1024, 2, 1, 1'b0, 1'b1);
    open_file(32'h0100, 8'd2, 1'b1);
    wait_done(3000);
    repeat (30) @(negedge clk);
    check("t5.no_third_req", 32'(f_wr_req), 32'd0);
    check("t5.fifo_left", 32'(fifo_cnt), 32'd512);
    pulse_reset();
    fq.delete();
    fifo_sync();
    sel_f = 1'b0;

    // Empty file
    expect_done(0, 0, 0, 1'b0, 1'b0);
    open_file(32'h5000, 8'd8, 1'b0);
    pulse_flush();
    wait_done(50);

    // Reset during a sector transfer
    xidx = 0;
    push_data(512, 13);
    expect_sector(32'h6000, 0, 512, 13);
    open_file(32'h6000, 8'd8, 1'b0);
    k = 0;
    while (xidx < 50 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("t7.in_xfer", 32'(xidx >= 50), 32'd1);
    d0 = done_seen;
    @(negedge clk); nreset = 1'b0;
    @(negedge clk);
    check("t7.busy", 32'(m_busy), 32'd0);
    check("t7.wr_req", 32'(m_wr_req), 32'd0);
    check("t7.byte_cnt", m_byte_cnt, 32'd0);
    check("t7.sec_cnt", m_sec_cnt, 32'd0);
    check("t7.clst_cnt", 32'(m_clst_cnt), 32'd0);
    check("t7.wr_sec", m_wr_sec, 32'd0);
    check("t7.dat_out", 32'(m_dat_out), 32'd0);
    @(negedge clk); nreset = 1'b1;
    exp_byte.delete();
    fq.delete();
    fifo_sync();
    repeat (20) @(negedge clk);
    check("t7.no_done", 32'(done_seen), 32'(d0));
    check("t7.idle_busy", 32'(m_busy), 32'd0);

    check("end.exp_sec_left", 32'(exp_sec.size()), 32'd0);
    check("end.exp_done_left", 32'(exp_done.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
